fibo_bcd_convert: RTL and testbench

FIBO_BCD_CONVERT -- requirements
Module: fibo_bcd_convert

---
 rtl/fibo_pkg.sv | 21 ++
 rtl/fibo_bcd_convert_if.sv | 40 ++++
 rtl/bcd_add3.sv | 22 ++
 rtl/fibo_bcd_convert.sv | 112 +++++++++++
 tb/tb_fibo_bcd_convert.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/fibo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fibo_pkg
//  Brief    : Shared types and constants for the Fibonacci BCD converter.
//  Revision : 1.0 - initial release
// ============================================================================
package fibo_pkg;

    // Default binary input width and number of BCD output digits
    localparam int BIN_W  = 16;
    localparam int DIGITS = 5;

    // Converter control states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage : fibo_pkg
`default_nettype wire

// File: rtl/fibo_bcd_convert_if.sv
`default_nettype none
// ============================================================================
//  Module   : fibo_bcd_convert_if
//  Brief    : Request/result bundle between the Fibonacci source and the
//             binary-to-BCD converter.
//  Revision : 1.0 - initial release
// ============================================================================
interface fibo_bcd_convert_if
    import fibo_pkg::*;
#(
    parameter int BIN_W  = fibo_pkg::BIN_W,
    parameter int DIGITS = fibo_pkg::DIGITS
);

    logic                  start;
    logic [BIN_W-1:0]      bin_in;
    logic [DIGITS*4-1:0]   bcd_out;
    logic                  busy;
    logic                  valid;

    // Upstream side: issues requests, observes results
    modport master (
        output start,
        output bin_in,
        input  bcd_out,
        input  busy,
        input  valid
    );

    // Converter side
    modport slave (
        input  start,
        input  bin_in,
        output bcd_out,
        output busy,
        output valid
    );

endinterface : fibo_bcd_convert_if
`default_nettype wire

// File: rtl/bcd_add3.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_add3
//  Brief    : Double-dabble digit correction: adds 3 to a BCD digit >= 5.
//             The sum stays 4 bits; a digit >= 5 never exceeds 12 after +3.
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_add3 (
    input  wire logic [3:0] i_digit,
    output logic      [3:0] o_digit
);

    // Pre-shift correction so the following left shift carries into the next digit
    always_comb begin
        o_digit = i_digit;
        if (i_digit >= 4'd5) begin
            o_digit = i_digit + 4'd3;
        end
    end

endmodule : bcd_add3
`default_nettype wire

// File: rtl/fibo_bcd_convert.sv
`default_nettype none
// ============================================================================
//  Module   : fibo_bcd_convert
//  Brief    : Sequential shift-and-add-3 binary to packed BCD converter.
//             One shift per cycle; result is valid BIN_W cycles after the
//             rising edge of start is sampled in IDLE.
//  Revision : 1.0 - initial release
// ============================================================================
module fibo_bcd_convert
    import fibo_pkg::*;
#(
    parameter int BIN_W  = fibo_pkg::BIN_W,
    parameter int DIGITS = fibo_pkg::DIGITS
) (
    input  wire logic          clk,
    input  wire logic          reset,
    fibo_bcd_convert_if.slave  bus
);

    localparam int BCD_W = DIGITS * 4;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(BIN_W - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_start_q;
    logic [CNT_W-1:0]   r_cnt;
    logic [SR_W-1:0]    r_shift;
    logic [BCD_W-1:0]   r_bcd;

    logic               w_rise;
    logic               w_last;
    logic [BCD_W-1:0]   w_adj_bcd;
    logic [SR_W-1:0]    w_adj_all;
    logic [SR_W-1:0]    w_shifted;

    assign w_rise = bus.start & ~r_start_q;
    assign w_last = (r_cnt == c_last_cnt);

    // Per-digit add-3 correction on the BCD field of the shift register
    for (genvar d = 0; d < DIGITS; d++) begin : g_digit
        bcd_add3 u_add3 (
            .i_digit (r_shift[BIN_W + d*4 +: 4]),
            .o_digit (w_adj_bcd[d*4 +: 4])
        );
    end

    assign w_adj_all = {w_adj_bcd, r_shift[BIN_W-1:0]};
    assign w_shifted = w_adj_all << 1;

    // Edge detector history: tracked in every state so held levels never retrigger
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_start_q <= 1'b0;
        end else begin
            r_start_q <= bus.start;
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: rises outside IDLE are dropped, DONE lasts one cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_rise) w_state_nxt = CONVERT;
            CONVERT: if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath: load on accepted request, correct-and-shift while converting
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_shift <= '0;
            r_bcd   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_shift <= {{BCD_W{1'b0}}, bus.bin_in};
                        r_cnt   <= '0;
                    end
                end
                CONVERT: begin
                    r_shift <= w_shifted;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_bcd <= w_shifted[SR_W-1 -: BCD_W];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.bcd_out = r_bcd;
    assign bus.busy    = (r_state == CONVERT);
    assign bus.valid   = (r_state == DONE);

endmodule : fibo_bcd_convert
`default_nettype wire

// File: tb/tb_fibo_bcd_convert.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fibo_bcd_convert
//  Brief    : Scoreboard bench for fibo_bcd_convert with a decimal reference.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fibo_bcd_convert;
    import fibo_pkg::*;

    localparam int BW = BIN_W;
    localparam int DG = DIGITS;

    logic clk;
    logic reset;

    fibo_bcd_convert_if #(.BIN_W(BW), .DIGITS(DG)) bus ();

    fibo_bcd_convert #(.BIN_W(BW), .DIGITS(DG)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [DG*4-1:0] bcd;
        int              due;
    } exp_t;

    exp_t            q[$];
    int              cyc        = 0;
    int              free_at    = 0;
    logic            prev_start = 1'b0;
    int              checks     = 0;
    int              errors     = 0;
    logic [DG*4-1:0] last_bcd   = '0;
    logic            exp_valid;
    logic            exp_busy;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Decimal digits by plain division
    function automatic logic [DG*4-1:0] to_bcd(int unsigned v);
        logic [DG*4-1:0] r;
        int unsigned     x;
        r = '0;
        x = v;
        for (int i = 0; i < DG; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Reference: a fresh 0->1 of start at an edge is accepted only when the
    // converter is idle; its result appears BW edges later, and the block is
    // idle again two edges after that.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (reset) begin
            q.delete();
            free_at    = 0;
            prev_start = 1'b0;
        end else begin
            if (bus.start && !prev_start && cyc >= free_at) begin
                q.push_back('{bcd: to_bcd(32'(bus.bin_in)), due: cyc + BW});
                free_at = cyc + BW + 2;
            end
            prev_start = bus.start;
        end
    end

    // Monitor on the falling edge
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            last_bcd  = '0;
            exp_busy  = 1'b0;
            exp_valid = 1'b0;
        end else begin
            exp_valid = (q.size() > 0) && (q[0].due == cyc);
            exp_busy  = (q.size() > 0) && (cyc < q[0].due);
            if (exp_valid) last_bcd = q[0].bcd;
        end
        chk("valid",   32'(bus.valid),   32'(exp_valid));
        chk("busy",    32'(bus.busy),    32'(exp_busy));
        chk("bcd_out", 32'(bus.bcd_out), 32'(last_bcd));
        if (!reset && q.size() > 0 && q[0].due <= cyc) void'(q.pop_front());
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [BW-1:0] v);
        bus.bin_in = v;
        bus.start  = 1'b1;
        idle(1);
        bus.start  = 1'b0;
    endtask

    // Stimulus
    initial begin
        reset      = 1'b0;
        bus.start  = 1'b0;
        bus.bin_in = '0;
        #1 reset = 1'b1;
        idle(3);
        reset = 1'b0;

        // Corner values
        pulse(BW'(0));     idle(20);
        pulse(BW'(65535)); idle(20);
        pulse(BW'(4181));  idle(20);

        // Held request: one conversion only
        bus.bin_in = BW'(987);
        bus.start  = 1'b1;
        idle(40);
        bus.start  = 1'b0;
        idle(4);

        // Second rise while converting, with a changed input, is ignored
        pulse(BW'(555)); idle(3);
        pulse(BW'(1));   idle(20);

        // Reset mid-conversion, then a fresh conversion
        pulse(BW'(777)); idle(7);
        reset = 1'b1;    idle(2);
        reset = 1'b0;
        pulse(BW'(610)); idle(20);

        // Back-to-back: release then re-raise shortly after completion
        bus.bin_in = BW'(1234);
        bus.start  = 1'b1; idle(16);
        bus.start  = 1'b0; idle(1);
        bus.bin_in = BW'(4321);
        bus.start  = 1'b1; idle(20);
        bus.start  = 1'b0; idle(4);

        // Start already high when reset is released
        reset      = 1'b1;
        bus.start  = 1'b1;
        bus.bin_in = BW'(2584);
        idle(2);
        reset = 1'b0;
        idle(20);
        bus.start = 1'b0;
        idle(2);

        // Random start toggling and input changes
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 3) == 0) bus.start = ~bus.start;
            if ($urandom_range(0, 1) == 1) bus.bin_in = BW'($urandom);
            idle(1);
        end
        bus.start = 1'b0;
        idle(25);

        chk("drain", 32'(q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_fibo_bcd_convert
`default_nettype wire
